// File: rtl/trap_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// trap_ctrl_pkg
// Shared definitions for the machine-mode trap sequencer: datapath width,
// CSR addresses, exception cause codes, mstatus bit positions, the sequencer
// state encoding and the mtval source selector.
// -----------------------------------------------------------------------------
package trap_ctrl_pkg;

   localparam int XLEN = 32;

   // CSR addresses written by the sequencer
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   // Synchronous exception cause codes
   localparam logic [3:0] CAUSE_MISAL  = 4'd0;
   localparam logic [3:0] CAUSE_ILLG   = 4'd2;
   localparam logic [3:0] CAUSE_EBREAK = 4'd3;
   localparam logic [3:0] CAUSE_ECALL  = 4'd11;

   // mstatus field positions
   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_MEPC    = 3'd1,
      S_MCAUSE  = 3'd2,
      S_MTVAL   = 3'd3,
      S_MSTATUS = 3'd4,
      S_MRET    = 3'd5,
      S_JUMP    = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      TVAL_ZERO = 2'd0,
      TVAL_PC   = 2'd1,
      TVAL_INST = 2'd2
   } tval_sel_t;

endpackage

// File: rtl/trap_cause_enc.sv
// -----------------------------------------------------------------------------
// trap_cause_enc
// Combinational priority encoder for the trap cause of the WB instruction.
// Priority: interrupt > misaligned fetch > illegal > ebreak > ecall.
//
// Ports
//   i_int_flag         interrupt tagged on the instruction
//   i_int_code         interrupt cause code
//   i_inst_addr_misal  instruction address misaligned
//   i_is_illg          illegal instruction
//   i_is_ebreak        ebreak
//   i_is_ecall         ecall
//   o_is_int           cause is an interrupt
//   o_code             cause code (low bits of mcause)
//   o_tval_sel         source for mtval
// -----------------------------------------------------------------------------
module trap_cause_enc
   import trap_ctrl_pkg::*;
(
   input  logic       i_int_flag,
   input  logic [3:0] i_int_code,
   input  logic       i_inst_addr_misal,
   input  logic       i_is_illg,
   input  logic       i_is_ebreak,
   input  logic       i_is_ecall,
   output logic       o_is_int,
   output logic [3:0] o_code,
   output tval_sel_t  o_tval_sel
);

   always_comb begin
      o_is_int   = 1'b0;
      o_code     = CAUSE_MISAL;
      o_tval_sel = TVAL_ZERO;
      if (i_int_flag) begin
         o_is_int = 1'b1;
         o_code   = i_int_code;
      end else if (i_inst_addr_misal) begin
         o_code     = CAUSE_MISAL;
         o_tval_sel = TVAL_PC;
      end else if (i_is_illg) begin
         o_code     = CAUSE_ILLG;
         o_tval_sel = TVAL_INST;
      end else if (i_is_ebreak) begin
         o_code = CAUSE_EBREAK;
      end else if (i_is_ecall) begin
         o_code = CAUSE_ECALL;
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
// Machine-mode trap / mret sequencer. Accepts a trapping or mret instruction
// from WB while idle, then walks one CSR write per cycle and finishes with a
// single-cycle PC redirect. The pipeline is flushed and fetch held for the
// whole sequence.
//
// Ports
//   clk, rst_n              clock; asynchronous active-high reset
//   wb_valid, wb_pc, wb_inst  WB instruction
//   wb_exp_flag, wb_int_flag  exception / interrupt tags
//   wb_inst_addr_misal, wb_is_illg_inst, wb_is_ecall_inst,
//   wb_is_ebreak_inst, wb_is_mret_inst  trap/return qualifiers
//   int_code                interrupt cause code
//   csr_mtvec/mepc/mstatus  current CSR values (read live in each state)
//   csr_we/waddr/wdata      CSR write port
//   pipe_flush, trap_busy   high in every non-idle state
//   redirect_valid/pc       one-cycle PC redirect
// -----------------------------------------------------------------------------
module trap_ctrl
   import trap_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wb_valid,
   input  logic [XLEN-1:0] wb_pc,
   input  logic [XLEN-1:0] wb_inst,
   input  logic            wb_exp_flag,
   input  logic            wb_int_flag,
   input  logic            wb_inst_addr_misal,
   input  logic            wb_is_illg_inst,
   input  logic            wb_is_ecall_inst,
   input  logic            wb_is_ebreak_inst,
   input  logic            wb_is_mret_inst,
   input  logic [3:0]      int_code,
   input  logic [XLEN-1:0] csr_mtvec,
   input  logic [XLEN-1:0] csr_mepc,
   input  logic [XLEN-1:0] csr_mstatus,
   output logic            csr_we,
   output logic [11:0]     csr_waddr,
   output logic [XLEN-1:0] csr_wdata,
   output logic            pipe_flush,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            trap_busy
);

   state_t          r_state;
   state_t          w_next;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_tval;
   logic            r_is_int;
   logic [3:0]      r_code;
   logic            r_is_mret;

   logic            w_is_trap;
   logic            w_accept;
   logic            w_enc_int;
   logic [3:0]      w_enc_code;
   tval_sel_t       w_tval_sel;
   logic [XLEN-1:0] w_tval;

   // Trap entry: stack MIE into MPIE, disable interrupts, enter M-mode.
   function automatic logic [XLEN-1:0] f_mstatus_trap(input logic [XLEN-1:0] ms);
      logic [XLEN-1:0] v;
      v = ms;
      v[MSTATUS_MPIE] = ms[MSTATUS_MIE];
      v[MSTATUS_MIE]  = 1'b0;
      v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      return v;
   endfunction

   // Trap return: restore MIE from MPIE and set MPIE.
   function automatic logic [XLEN-1:0] f_mstatus_mret(input logic [XLEN-1:0] ms);
      logic [XLEN-1:0] v;
      v = ms;
      v[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
      v[MSTATUS_MPIE] = 1'b1;
      return v;
   endfunction

   // Vectored mode (mtvec[1:0]=01) offsets interrupts only by 4*code.
   function automatic logic [XLEN-1:0] f_trap_target(input logic [XLEN-1:0] tvec,
                                                     input logic is_int,
                                                     input logic [3:0] code);
      logic [XLEN-1:0] base;
      base = {tvec[XLEN-1:2], 2'b00};
      if (is_int && (tvec[1:0] == 2'b01))
         base = base + {{(XLEN-6){1'b0}}, code, 2'b00};
      return base;
   endfunction

   trap_cause_enc u_enc (
      .i_int_flag        (wb_int_flag),
      .i_int_code        (int_code),
      .i_inst_addr_misal (wb_inst_addr_misal),
      .i_is_illg         (wb_is_illg_inst),
      .i_is_ebreak       (wb_is_ebreak_inst),
      .i_is_ecall        (wb_is_ecall_inst),
      .o_is_int          (w_enc_int),
      .o_code            (w_enc_code),
      .o_tval_sel        (w_tval_sel)
   );

   // mret only wins when no exception/interrupt is tagged on the instruction.
   assign w_is_trap = wb_exp_flag | wb_int_flag;
   assign w_accept  = (r_state == S_IDLE) && wb_valid && (w_is_trap || wb_is_mret_inst);

   always_comb begin
      case (w_tval_sel)
         TVAL_PC:   w_tval = wb_pc;
         TVAL_INST: w_tval = wb_inst;
         default:   w_tval = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_state   <= S_IDLE;
         r_pc      <= '0;
         r_tval    <= '0;
         r_is_int  <= 1'b0;
         r_code    <= '0;
         r_is_mret <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_pc      <= wb_pc;
            r_tval    <= w_tval;
            r_is_int  <= w_enc_int;
            r_code    <= w_enc_code;
            r_is_mret <= ~w_is_trap;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_accept) w_next = w_is_trap ? S_MEPC : S_MRET;
         S_MEPC:    w_next = S_MCAUSE;
         S_MCAUSE:  w_next = S_MTVAL;
         S_MTVAL:   w_next = S_MSTATUS;
         S_MSTATUS: w_next = S_JUMP;
         S_MRET:    w_next = S_JUMP;
         S_JUMP:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // Outputs decode from state and latched trap info; mstatus, mtvec and
   // mepc are read live so the values current in each state are used.
   always_comb begin
      csr_we         = 1'b0;
      csr_waddr      = '0;
      csr_wdata      = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      pipe_flush     = (r_state != S_IDLE);
      trap_busy      = (r_state != S_IDLE);
      case (r_state)
         S_MEPC: begin
            csr_we    = 1'b1;
            csr_waddr = CSR_MEPC;
            csr_wdata = r_pc;
         end
         S_MCAUSE: begin
            csr_we    = 1'b1;
            csr_waddr = CSR_MCAUSE;
            csr_wdata = {r_is_int, {(XLEN-5){1'b0}}, r_code};
         end
         S_MTVAL: begin
            csr_we    = 1'b1;
            csr_waddr = CSR_MTVAL;
            csr_wdata = r_tval;
         end
         S_MSTATUS: begin
            csr_we    = 1'b1;
            csr_waddr = CSR_MSTATUS;
            csr_wdata = f_mstatus_trap(csr_mstatus);
         end
         S_MRET: begin
            csr_we    = 1'b1;
            csr_waddr = CSR_MSTATUS;
            csr_wdata = f_mstatus_mret(csr_mstatus);
         end
         S_JUMP: begin
            redirect_valid = 1'b1;
            redirect_pc    = r_is_mret ? csr_mepc : f_trap_target(csr_mtvec, r_is_int, r_code);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wb_valid = 1'b0;
   logic [31:0] wb_pc = '0, wb_inst = '0;
   logic        wb_exp_flag = 1'b0, wb_int_flag = 1'b0;
   logic        wb_inst_addr_misal = 1'b0, wb_is_illg_inst = 1'b0;
   logic        wb_is_ecall_inst = 1'b0, wb_is_ebreak_inst = 1'b0, wb_is_mret_inst = 1'b0;
   logic [3:0]  int_code = '0;
   logic [31:0] csr_mtvec = '0, csr_mepc = '0, csr_mstatus = '0;
   logic        csr_we;
   logic [11:0] csr_waddr;
   logic [31:0] csr_wdata;
   logic        pipe_flush, redirect_valid, trap_busy;
   logic [31:0] redirect_pc;

   trap_ctrl dut (
      .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst),
      .wb_exp_flag(wb_exp_flag), .wb_int_flag(wb_int_flag),
      .wb_inst_addr_misal(wb_inst_addr_misal), .wb_is_illg_inst(wb_is_illg_inst),
      .wb_is_ecall_inst(wb_is_ecall_inst), .wb_is_ebreak_inst(wb_is_ebreak_inst),
      .wb_is_mret_inst(wb_is_mret_inst), .int_code(int_code),
      .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .csr_mstatus(csr_mstatus),
      .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
      .pipe_flush(pipe_flush), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .trap_busy(trap_busy)
   );

   typedef struct {
      int          cyc;
      bit          redir;
      logic [11:0] addr;
      logic [31:0] data;
   } ev_t;

   ev_t q[$];
   int  cyc = 0;
   int  busy_from = 0;
   int  busy_until = -1;
   int  n_checks = 0;
   int  n_err = 0;
   bit  mon_en = 1'b0;
   ev_t m_e;
   bit  m_eb;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int c, input bit r, input logic [11:0] a, input logic [31:0] d);
      ev_t e;
      e.cyc = c; e.redir = r; e.addr = a; e.data = d;
      q.push_back(e);
   endtask

   function automatic bit model_idle();
      return cyc > busy_until;
   endfunction

   // Reference model: the whole expected response of an accepted instruction,
   // derived from the architectural trap rules, is queued at acceptance time.
   task automatic model_accept(input bit ef, input bit inf, input logic [3:0] ic,
                               input bit misal, input bit illg, input bit ebrk,
                               input bit mret, input logic [31:0] pc, input logic [31:0] inst);
      int          n;
      bit          ii;
      int          code;
      logic [31:0] tval, ms, tgt;
      n  = cyc;
      ms = csr_mstatus;
      busy_from = n + 1;
      if (ef || inf) begin
         ii = 1'b0; tval = 32'h0;
         if (inf)        begin ii = 1'b1; code = int'(ic); end
         else if (misal) begin code = 0;  tval = pc;   end
         else if (illg)  begin code = 2;  tval = inst; end
         else if (ebrk)  code = 3;
         else            code = 11;
         push(n + 1, 1'b0, 12'h341, pc);
         push(n + 2, 1'b0, 12'h342, {ii, 31'(code)});
         push(n + 3, 1'b0, 12'h343, tval);
         ms[7] = csr_mstatus[3];
         ms[3] = 1'b0;
         ms[12:11] = 2'b11;
         push(n + 4, 1'b0, 12'h300, ms);
         tgt = csr_mtvec & ~32'h3;
         if (ii && csr_mtvec[1:0] == 2'b01) tgt = tgt + 32'(4 * code);
         push(n + 5, 1'b1, 12'h000, tgt);
         busy_until = n + 5;
      end else if (mret) begin
         ms[3] = csr_mstatus[7];
         ms[7] = 1'b1;
         push(n + 1, 1'b0, 12'h300, ms);
         push(n + 2, 1'b1, 12'h000, csr_mepc);
         busy_until = n + 2;
      end
   endtask

   task automatic drive(input bit v, input bit ef, input bit inf, input logic [3:0] ic,
                        input bit misal, input bit illg, input bit ebrk, input bit ecall,
                        input bit mret, input logic [31:0] pc, input logic [31:0] inst);
      wb_valid = v; wb_exp_flag = ef; wb_int_flag = inf; int_code = ic;
      wb_inst_addr_misal = misal; wb_is_illg_inst = illg; wb_is_ebreak_inst = ebrk;
      wb_is_ecall_inst = ecall; wb_is_mret_inst = mret; wb_pc = pc; wb_inst = inst;
      if (model_idle() && v && (ef || inf || mret))
         model_accept(ef, inf, ic, misal, illg, ebrk, mret, pc, inst);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
   endtask

   // Monitor: compares every CSR write / redirect against the queued model.
   always @(negedge clk) begin
      if (mon_en) begin
         m_eb = (cyc >= busy_from) && (cyc <= busy_until);
         n_checks++;
         if (pipe_flush !== m_eb || trap_busy !== m_eb) begin
            n_err++;
            $display("FAIL busy cyc=%0d flush=%b busy=%b required=%b", cyc, pipe_flush, trap_busy, m_eb);
         end
         while (q.size() > 0 && q[0].cyc < cyc) begin
            n_checks++; n_err++;
            $display("FAIL missed_event cyc=%0d required at %0d addr=%h data=%h", cyc, q[0].cyc, q[0].addr, q[0].data);
            void'(q.pop_front());
         end
         if (csr_we === 1'b1 || redirect_valid === 1'b1) begin
            n_checks++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_event cyc=%0d we=%b addr=%h wdata=%h redir=%b pc=%h", cyc, csr_we, csr_waddr, csr_wdata, redirect_valid, redirect_pc);
            end else begin
               m_e = q.pop_front();
               if (m_e.cyc != cyc || redirect_valid !== m_e.redir || csr_we !== !m_e.redir ||
                   (!m_e.redir && (csr_waddr !== m_e.addr || csr_wdata !== m_e.data)) ||
                   (m_e.redir && redirect_pc !== m_e.data)) begin
                  n_err++;
                  $display("FAIL event cyc=%0d we=%b addr=%h wdata=%h redir=%b pc=%h required cyc=%0d redir=%b addr=%h data=%h",
                           cyc, csr_we, csr_waddr, csr_wdata, redirect_valid, redirect_pc,
                           m_e.cyc, m_e.redir, m_e.addr, m_e.data);
               end
            end
         end
         n_checks++;
         if ((csr_we !== 1'b1 && (csr_waddr !== 12'h0 || csr_wdata !== 32'h0)) ||
             (redirect_valid !== 1'b1 && redirect_pc !== 32'h0)) begin
            n_err++;
            $display("FAIL idle_zero cyc=%0d addr=%h wdata=%h pc=%h required 0", cyc, csr_waddr, csr_wdata, redirect_pc);
         end
      end
   end

   initial begin
      logic [3:0] qual;
      bit v, ef, inf, mret;
      logic [3:0] ic;

      #1 rst_n = 1'b1;
      #2;
      n_checks++;
      if (csr_we !== 1'b0 || csr_waddr !== 12'h0 || csr_wdata !== 32'h0 || pipe_flush !== 1'b0 ||
          redirect_valid !== 1'b0 || redirect_pc !== 32'h0 || trap_busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state we=%b addr=%h wdata=%h flush=%b redir=%b pc=%h busy=%b required all 0",
                  csr_we, csr_waddr, csr_wdata, pipe_flush, redirect_valid, redirect_pc, trap_busy);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      mon_en = 1'b1;
      idle(2);

      // Illegal instruction
      csr_mtvec = 32'h200; csr_mstatus = 32'h0000_0008; csr_mepc = 32'h0;
      drive(1, 1, 0, 4'd0, 0, 1, 0, 0, 0, 32'h100, 32'hFFFF_FFFF);
      idle(7);

      // Timer interrupt, vectored mtvec
      csr_mtvec = 32'h201; csr_mstatus = 32'h0000_0000;
      drive(1, 0, 1, 4'd7, 0, 0, 0, 0, 0, 32'h180, 32'h0000_0013);
      idle(7);

      // mret: MPIE=1, MIE=0
      csr_mepc = 32'h400; csr_mstatus = 32'h0000_0080;
      drive(1, 0, 0, 4'd0, 0, 0, 0, 0, 1, 32'h300, 32'h3020_0073);
      idle(4);

      // ecall and illegal together: illegal wins
      csr_mtvec = 32'h1000; csr_mstatus = 32'h0000_1888;
      drive(1, 1, 0, 4'd0, 0, 1, 0, 1, 0, 32'h240, 32'h0000_0073);
      idle(7);

      // Second trap during MCAUSE is ignored
      csr_mtvec = 32'h800;
      drive(1, 1, 0, 4'd0, 0, 0, 1, 0, 0, 32'h500, 32'h0010_0073);
      idle(1);
      drive(1, 1, 1, 4'd11, 1, 1, 1, 1, 1, 32'h600, 32'h1234_5678);
      idle(6);

      // Reset pulsed while in MTVAL aborts the sequence
      drive(1, 1, 0, 4'd0, 1, 0, 0, 0, 0, 32'h702, 32'h0);
      idle(2);
      @(negedge clk); #1;
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (trap_busy !== 1'b0 || pipe_flush !== 1'b0 || csr_we !== 1'b0 || redirect_valid !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset busy=%b flush=%b we=%b redir=%b required 0", trap_busy, pipe_flush, csr_we, redirect_valid);
      end
      rst_n = 1'b0;
      q.delete();
      busy_until = cyc;
      @(posedge clk); #1;
      idle(4);

      // Randomized traffic; CSR inputs only change while the model is idle
      for (int i = 0; i < 600; i++) begin
         if (model_idle()) begin
            csr_mtvec   = {$urandom_range(0, 32'h3FFF_FFFF), 1'b0, 1'($urandom_range(0, 1))};
            csr_mepc    = $urandom;
            csr_mstatus = $urandom;
         end
         v    = ($urandom_range(0, 2) == 0);
         ef   = ($urandom_range(0, 2) == 0);
         inf  = ($urandom_range(0, 3) == 0);
         mret = ($urandom_range(0, 1) == 1);
         qual = ef ? 4'($urandom_range(1, 15)) : 4'($urandom_range(0, 15));
         case ($urandom_range(0, 2))
            0:       ic = 4'd3;
            1:       ic = 4'd7;
            default: ic = 4'd11;
         endcase
         drive(v, ef, inf, ic, qual[0], qual[1], qual[2], qual[3], mret, $urandom, $urandom);
      end
      idle(8);

      n_checks++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL leftover_events got %0d pending required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
